// File: rtl/intc_requester.sv
// Interrupt requester (macro INTC_TIMEOUT_EN adds WAIT_RET abort): syncs/edge-detects two lines, masks, src0 wins.
// Request goes out one edge after pend is visible; new requests are blocked until irep returns plus GAP_CYCLES.
module intc_requester #(
   parameter int SYNC_STAGES = 2,
   parameter int REQ_CYCLES  = 3,
   parameter int GAP_CYCLES  = 1,
   parameter int RET_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] irq_src,
   input  logic       mask_we,
   input  logic [1:0] mask_wdata,
   input  logic       irep,
   output logic       ireq,
   output logic [1:0] ivec,
   output logic       busy,
   output logic [1:0] pend,
   output logic [1:0] mask,
   output logic [1:0] in_service,
   output logic       ret_timeout
);

   if (SYNC_STAGES < 2 || REQ_CYCLES < 1 || GAP_CYCLES < 1 || RET_TIMEOUT < 1) begin : g_bad_params
      $error("intc_requester: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RET, GAP} state_t;

   localparam int CNT_MAX = (REQ_CYCLES > GAP_CYCLES) ? REQ_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic [SYNC_STAGES-1:0][1:0]  sync_q;
   logic [1:0]                   src_prev;
   logic [1:0]                   src_rise;
   logic [1:0]                   eligible;
   logic [1:0]                   winner;
   logic                         irep_q;
   logic                         irep_rise;
   logic                         timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         src_prev <= '0;
         irep_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_src};
         src_prev <= sync_q[SYNC_STAGES-1];
         irep_q   <= irep;
      end
   end

   assign src_rise  = sync_q[SYNC_STAGES-1] & ~src_prev;
   assign irep_rise = irep & ~irep_q;
   assign busy      = (state != IDLE);
   assign eligible  = pend & ~mask & ~{2{busy}};
   assign winner    = eligible[0] ? 2'b01 : (eligible[1] ? 2'b10 : 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ireq       <= 1'b0;
         ivec       <= 2'b00;
         in_service <= 2'b00;
         pend       <= 2'b00;
         mask       <= 2'b00;
      end else begin
         // winner is only non-zero in IDLE; a same-cycle edge re-sets the bit
         pend <= (pend & ~winner) | src_rise;
         if (mask_we)
            mask <= mask_wdata;
         case (state)
            IDLE: begin
               if (winner != 2'b00) begin
                  ireq       <= 1'b1;
                  ivec       <= winner;
                  in_service <= winner;
                  cnt        <= CNT_W'(1);
                  state      <= REQ;
               end
            end
            REQ: begin
               if (cnt == CNT_W'(REQ_CYCLES)) begin
                  ireq  <= 1'b0;
                  ivec  <= 2'b00;
                  state <= WAIT_RET;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_RET: begin
               if (irep_rise || timeout_hit) begin
                  in_service <= 2'b00;
                  cnt        <= CNT_W'(1);
                  state      <= GAP;
               end
            end
            GAP: begin
               if (cnt == CNT_W'(GAP_CYCLES))
                  state <= IDLE;
               else
                  cnt <= cnt + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INTC_TIMEOUT_EN
   localparam int WCNT_W = $clog2(RET_TIMEOUT + 1);

   logic [WCNT_W-1:0] wcnt;

   // A return arriving on the last allowed cycle still counts as a normal return
   assign timeout_hit = (state == WAIT_RET) && !irep_rise && (wcnt == WCNT_W'(RET_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt        <= '0;
         ret_timeout <= 1'b0;
      end else begin
         ret_timeout <= timeout_hit;
         wcnt        <= (state == WAIT_RET) ? wcnt + WCNT_W'(1) : '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign ret_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_intc_requester.sv
// Bench for intc_requester: directed scenarios with hand-derived timing, then random traffic against a
// timestamp-based reference model.
module tb_intc_requester;
   localparam int S   = 2;
   localparam int REQ = 3;
   localparam int GAP = 1;
   localparam int RTO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] irq_src;
   logic       mask_we;
   logic [1:0] mask_wdata;
   logic       irep;
   logic       ireq;
   logic [1:0] ivec;
   logic       busy;
   logic [1:0] pend;
   logic [1:0] mask;
   logic [1:0] in_service;
   logic       ret_timeout;

   int total  = 0;
   int passed = 0;

   intc_requester #(
      .SYNC_STAGES(S), .REQ_CYCLES(REQ), .GAP_CYCLES(GAP), .RET_TIMEOUT(RTO)
   ) dut (
      .clk(clk), .rst(rst), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .irep(irep), .ireq(ireq), .ivec(ivec), .busy(busy), .pend(pend), .mask(mask),
      .in_service(in_service), .ret_timeout(ret_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      irq_src = 2'b00; irep = 1'b0; mask_we = 1'b0; mask_wdata = 2'b00;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   // Pulses irep whenever the DUT sits in WAIT_RET, until it is idle again
   task automatic drain();
      int n = 0;
      while (busy && n < 60) begin
         irep = (!ireq && in_service != 2'b00 && !irep);
         step();
         n++;
      end
      irep = 1'b0;
      total++; if (busy !== 1'b0) $display("FAIL drain_idle: busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1; irq_src = 2'b11; irep = 1'b1; mask_we = 1'b1; mask_wdata = 2'b11;
      step(); step(); step();
      total++; if (ireq !== 1'b0) $display("FAIL reset_ireq: got %b want 0", ireq); else passed++;
      total++; if (ivec !== 2'b00) $display("FAIL reset_ivec: got %b want 00", ivec); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (pend !== 2'b00) $display("FAIL reset_pend: got %b want 00", pend); else passed++;
      total++; if (mask !== 2'b00) $display("FAIL reset_mask: got %b want 00", mask); else passed++;
      total++; if (in_service !== 2'b00) $display("FAIL reset_insvc: got %b want 00", in_service); else passed++;
      total++; if (ret_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", ret_timeout); else passed++;
      irq_src = 2'b00; irep = 1'b0; mask_we = 1'b0; mask_wdata = 2'b00;
      step();
      rst = 1'b0;
      step(); step(); step(); step();
      total++; if (pend !== 2'b00) $display("FAIL reset_no_spurious_pend: got %b want 00", pend); else passed++;
   endtask

   task automatic test_single();
      int hi;
      do_reset();
      irq_src = 2'b01;
      step(); step();
      total++; if (pend !== 2'b00) $display("FAIL single_pend_early: got %b want 00", pend); else passed++;
      step();
      total++; if (pend !== 2'b01) $display("FAIL single_pend_set: got %b want 01", pend); else passed++;
      total++; if (ireq !== 1'b0) $display("FAIL single_ireq_early: got %b want 0", ireq); else passed++;
      step();
      total++; if (ireq !== 1'b1) $display("FAIL single_ireq: got %b want 1", ireq); else passed++;
      total++; if (ivec !== 2'b01) $display("FAIL single_ivec: got %b want 01", ivec); else passed++;
      total++; if (in_service !== 2'b01) $display("FAIL single_insvc: got %b want 01", in_service); else passed++;
      total++; if (pend !== 2'b00) $display("FAIL single_pend_clr: got %b want 00", pend); else passed++;
      hi = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (ireq) hi++;
      end
      total++; if (hi != REQ) $display("FAIL single_req_len: got %0d want %0d", hi, REQ); else passed++;
      total++; if (in_service !== 2'b01 || busy !== 1'b1) $display("FAIL single_wait_ret: insvc/busy got %b/%b want 01/1", in_service, busy); else passed++;
      drain();
   endtask

   task automatic test_simultaneous();
      do_reset();
      irq_src = 2'b11;
      step(); step(); step();
      total++; if (pend !== 2'b11) $display("FAIL simul_pend: got %b want 11", pend); else passed++;
      step();
      total++; if (ireq !== 1'b1 || ivec !== 2'b01) $display("FAIL simul_first: ireq/ivec got %b/%b want 1/01", ireq, ivec); else passed++;
      total++; if (pend !== 2'b10) $display("FAIL simul_pend_kept: got %b want 10", pend); else passed++;
      step(); step(); step();
      total++; if (ireq !== 1'b0 || in_service !== 2'b01) $display("FAIL simul_wait: ireq/insvc got %b/%b want 0/01", ireq, in_service); else passed++;
      irep = 1'b1;
      step();
      irep = 1'b0;
      total++; if (in_service !== 2'b00 || busy !== 1'b1) $display("FAIL simul_gap: insvc/busy got %b/%b want 00/1", in_service, busy); else passed++;
      step();
      total++; if (ireq !== 1'b0 || busy !== 1'b0) $display("FAIL simul_idle: ireq/busy got %b/%b want 0/0", ireq, busy); else passed++;
      step();
      total++; if (ireq !== 1'b1 || ivec !== 2'b10) $display("FAIL simul_second: ireq/ivec got %b/%b want 1/10", ireq, ivec); else passed++;
      total++; if (pend !== 2'b00 || in_service !== 2'b10) $display("FAIL simul_second_state: pend/insvc got %b/%b want 00/10", pend, in_service); else passed++;
      drain();
   endtask

   task automatic test_mask();
      do_reset();
      mask_we = 1'b1; mask_wdata = 2'b01;
      step();
      mask_we = 1'b0;
      total++; if (mask !== 2'b01) $display("FAIL mask_write: got %b want 01", mask); else passed++;
      irq_src = 2'b01;
      for (int i = 0; i < 6; i++) step();
      total++; if (pend !== 2'b01) $display("FAIL mask_pend_latched: got %b want 01", pend); else passed++;
      total++; if (ireq !== 1'b0 || busy !== 1'b0) $display("FAIL mask_blocks: ireq/busy got %b/%b want 0/0", ireq, busy); else passed++;
      mask_we = 1'b1; mask_wdata = 2'b00;
      step();
      mask_we = 1'b0;
      total++; if (mask !== 2'b00 || ireq !== 1'b0) $display("FAIL mask_clear: mask/ireq got %b/%b want 00/0", mask, ireq); else passed++;
      step();
      total++; if (ireq !== 1'b1 || ivec !== 2'b01) $display("FAIL mask_release: ireq/ivec got %b/%b want 1/01", ireq, ivec); else passed++;
      mask_we = 1'b1; mask_wdata = 2'b11;
      step();
      mask_we = 1'b0;
      total++; if (ireq !== 1'b1 || mask !== 2'b11) $display("FAIL mask_no_abort: ireq/mask got %b/%b want 1/11", ireq, mask); else passed++;
      drain();
   endtask

   task automatic test_reedge();
      do_reset();
      irq_src = 2'b10;
      step(); step(); step(); step();
      total++; if (ivec !== 2'b10) $display("FAIL reedge_first: ivec got %b want 10", ivec); else passed++;
      irq_src = 2'b00;
      step(); step(); step();
      total++; if (ireq !== 1'b0 || pend !== 2'b00) $display("FAIL reedge_wait: ireq/pend got %b/%b want 0/00", ireq, pend); else passed++;
      irq_src = 2'b10;
      step(); step(); step();
      total++; if (pend !== 2'b10 || in_service !== 2'b10) $display("FAIL reedge_pend: pend/insvc got %b/%b want 10/10", pend, in_service); else passed++;
      irep = 1'b1;
      step();
      irep = 1'b0;
      total++; if (ireq !== 1'b0 || in_service !== 2'b00) $display("FAIL reedge_ret: ireq/insvc got %b/%b want 0/00", ireq, in_service); else passed++;
      step();
      total++; if (ireq !== 1'b0) $display("FAIL reedge_gap_low: got %b want 0", ireq); else passed++;
      step();
      total++; if (ireq !== 1'b1 || ivec !== 2'b10 || pend !== 2'b00) $display("FAIL reedge_again: ireq/ivec/pend got %b/%b/%b want 1/10/00", ireq, ivec, pend); else passed++;
      drain();
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      irq_src = 2'b01;
      step(); step(); step(); step();
      irq_src = 2'b00;
      step();
      total++; if (ireq !== 1'b1) $display("FAIL rstmid_in_req: got %b want 1", ireq); else passed++;
      rst = 1'b1;
      step();
      total++; if ({ireq, ivec, busy, pend, mask, in_service, ret_timeout} !== 11'b0)
         $display("FAIL rstmid_outputs: got %b want 00000000000", {ireq, ivec, busy, pend, mask, in_service, ret_timeout}); else passed++;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (ireq !== 1'b0 || pend !== 2'b00) bad++;
      end
      total++; if (bad != 0) $display("FAIL rstmid_no_resume: active cycles got %0d want 0", bad); else passed++;
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      irq_src = 2'b01;
      for (int i = 0; i < 7; i++) step();
`ifdef INTC_TIMEOUT_EN
      for (int i = 0; i < RTO - 1; i++) begin
         step();
         if (ret_timeout) n++;
      end
      total++; if (n != 0 || busy !== 1'b1) $display("FAIL timeout_early: pulses/busy got %0d/%b want 0/1", n, busy); else passed++;
      step();
      total++; if (ret_timeout !== 1'b1 || in_service !== 2'b00) $display("FAIL timeout_pulse: to/insvc got %b/%b want 1/00", ret_timeout, in_service); else passed++;
      total++; if (busy !== 1'b1 || pend !== 2'b00) $display("FAIL timeout_gap: busy/pend got %b/%b want 1/00", busy, pend); else passed++;
      step();
      total++; if (ret_timeout !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_idle: to/busy got %b/%b want 0/0", ret_timeout, busy); else passed++;
`else
      for (int i = 0; i < 300; i++) begin
         step();
         if (busy !== 1'b1 || ret_timeout !== 1'b0) n++;
      end
      total++; if (n != 0 || in_service !== 2'b01) $display("FAIL no_timeout_hold: bad cycles/insvc got %0d/%b want 0/01", n, in_service); else passed++;
      drain();
`endif
   endtask

   // Reference model tracks a transaction by its start edge s and return edge r
   task automatic test_random();
      logic [1:0]  hist[$];
      logic [1:0]  m_pend = 2'b00, m_mask = 2'b00, m_served = 2'b00, sel, rise, a, b;
      logic [1:0]  c_src, c_wd;
      logic        c_we, c_irep, m_irep_prev = 1'b0, in_tx = 1'b0, r_set = 1'b0, exp_to, exp_ireq;
      logic [10:0] exp_v, act_v;
      int          s = 0, r = 0;
      do_reset();
      for (int e = 0; e < 800; e++) begin
         if ($urandom_range(0, 7) == 0) irq_src[0] = ~irq_src[0];
         if ($urandom_range(0, 7) == 0) irq_src[1] = ~irq_src[1];
         irep       = ($urandom_range(0, 5) == 0);
         mask_we    = ($urandom_range(0, 19) == 0);
         mask_wdata = 2'($urandom_range(0, 3));
         c_src = irq_src; c_irep = irep; c_we = mask_we; c_wd = mask_wdata;
         step();
         hist.push_back(c_src);
         a = (e - S >= 0) ? hist[e - S] : 2'b00;
         b = (e - S - 1 >= 0) ? hist[e - S - 1] : 2'b00;
         rise   = a & ~b;
         exp_to = 1'b0;
         sel    = 2'b00;
         if (!in_tx) begin
            if (m_pend[0] && !m_mask[0]) sel = 2'b01;
            else if (m_pend[1] && !m_mask[1]) sel = 2'b10;
         end
         if (sel != 2'b00) begin
            in_tx = 1'b1; s = e; r_set = 1'b0; m_served = sel;
         end else if (in_tx && !r_set && e >= s + REQ + 1 && c_irep && !m_irep_prev) begin
            r_set = 1'b1; r = e;
         end
`ifdef INTC_TIMEOUT_EN
         else if (in_tx && !r_set && e == s + REQ + RTO) begin
            r_set = 1'b1; r = e; exp_to = 1'b1;
         end
`endif
         if (in_tx && r_set && e >= r + GAP) in_tx = 1'b0;
         m_irep_prev = c_irep;
         m_pend = (m_pend & ~sel) | rise;
         if (c_we) m_mask = c_wd;
         exp_ireq = in_tx && (e <= s + REQ - 1);
         exp_v = {exp_ireq, exp_ireq ? m_served : 2'b00, in_tx, m_pend, m_mask,
                  (in_tx && !r_set) ? m_served : 2'b00, exp_to};
         act_v = {ireq, ivec, busy, pend, mask, in_service, ret_timeout};
         total++;
         if (act_v !== exp_v) $display("FAIL random_cycle%0d {ireq,ivec,busy,pend,mask,insvc,to}: got %b want %b", e, act_v, exp_v);
         else passed++;
      end
      irq_src = 2'b00; mask_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq_src = 2'b00; irep = 1'b0; mask_we = 1'b0; mask_wdata = 2'b00;
      test_reset();
      test_single();
      test_simultaneous();
      test_mask();
      test_reedge();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/intc_requester.md
Name: intc_requester

Overview:
- Interrupt request generator; drives the coprocessor's interrupt-request side (ireq, ivec), and consumes its return strobe irep.
- Collects two asynchronous device interrupt lines and synchronizes and edge-detects them. Latches them as pending, applies a mask and fixed priority, then issues one request at a time.
- Holds ireq for the fixed window the coprocessor expects, then blocks further requests until the in-service interrupt returns.

Parameters:
SYNC_STAGES, 2, synchronizer flops per source line (min 2)
REQ_CYCLES, 3, cycles ireq/ivec held high per request (min 1)
GAP_CYCLES, 1, forced ireq-low cycles after return, before next request (min 1)
RET_TIMEOUT, 255, max WAIT_RET cycles before abort (used only with INTC_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
irq_src  in  2  async device interrupt lines, rising-edge triggered
mask_we  in  1  mask write strobe
mask_wdata  in  2  new mask value (1 = masked)
irep  in  1  return-from-interrupt from core, level, sampled synchronously
ireq  out  1  interrupt request to coprocessor
ivec  out  2  one-hot vector select: 01 = vector 0, 10 = vector 1, 00 when ireq low
busy  out  1  high whenever state != IDLE
pend  out  2  pending bits
mask  out  2  current mask
in_service  out  2  one-hot source currently being served
ret_timeout  out  1  one-cycle pulse on return timeout

Behaviour:
- Reset values: ireq=0, ivec=00, busy=0, pend=00, mask=00, in_service=00, ret_timeout=0. All synchronizer and edge flops are cleared. State is IDLE and counters are 0. Reset mid-operation aborts immediately; ireq is low after the reset edge.
- Sync/edge:
  - Each irq_src bit passes through SYNC_STAGES flops. A rising edge is the synced value 1 with the previous synced value 0.
  - A src high first sampled at edge 0 sets pend at edge SYNC_STAGES.
- Pend set/clear:
  - A detected edge sets the pend bit.
  - The pend bit is cleared when that source is selected (IDLE->REQ).
  - Set and clear in the same cycle: set wins, so the bit stays 1.
  - Repeated edges while pending are not counted.
- Mask:
  - On mask_we, mask <= mask_wdata at the next edge.
  - A mask does not suppress pend latching; it only blocks selection.
  - Mask writes never abort a request already in REQ/WAIT_RET.
- Eligible = pend & ~mask & ~{2{busy}}. Priority is fixed: source 0 over source 1.
- FSM:
  - IDLE: if eligible != 0, at the next edge: ireq=1, ivec = one-hot of the winner, in_service = ivec, pend bit cleared, cnt=1, go to REQ. The request goes out one edge after pend is visible.
  - REQ: ireq/ivec are held stable. When cnt == REQ_CYCLES, at the next edge: ireq=0, ivec=00, go to WAIT_RET. Otherwise cnt++. ireq is high for exactly REQ_CYCLES cycles.
  - WAIT_RET: on the rising edge of synchronous irep (irep=1, previous irep=0): in_service=00, cnt=1, go to GAP.
  - GAP: ireq=0. When cnt == GAP_CYCLES, go to IDLE; otherwise cnt++.
- irep rising in IDLE, REQ or GAP is ignored (no state change). The irep-previous register tracks in all states.
- An edge on the in-service source during WAIT_RET sets pend. That source is served again after GAP.
- Minimum spacing between two ireq assertions: REQ_CYCLES + 1 (WAIT_RET) + GAP_CYCLES + 1 cycles.

Optional Feature:
- INTC_TIMEOUT_EN defined:
  - A WAIT_RET counter counts cycles spent in WAIT_RET.
  - If RET_TIMEOUT cycles pass with no irep rising edge: ret_timeout pulses for 1 cycle, in_service=00, go to GAP. The served pend bit is not restored.
- Undefined:
  - WAIT_RET waits indefinitely.
  - ret_timeout is tied 0 and no counter logic exists.

Test Plan:
- src0 rises, first sampled at edge 0 (defaults) -> pend=01 after edge 2. ireq=1 with ivec=01 after edge 3, for exactly 3 cycles. in_service=01 and pend=00 from the same edge.
- src0 and src1 rise in the same cycle -> ivec=01 first, pend=10 retained. After an irep pulse and a 1-cycle gap, a second request with ivec=10.
- mask=01, src0 rises -> pend=01 but no ireq. Write mask=00 -> ireq with ivec=01 two edges after mask_we.
- src1 re-edges during its own WAIT_RET -> pend=10 set. After irep it is served again; ireq low for ≥1 cycle between the two requests.
- rst asserted during the 2nd REQ cycle -> after the reset edge all outputs are at reset values. No request resumes without a new edge.
- INTC_TIMEOUT_EN with RET_TIMEOUT=8 and no irep -> ret_timeout pulses once 8 cycles after WAIT_RET entry. The FSM then goes via GAP to IDLE. Without the macro, busy stays 1 indefinitely.
